i4003_loader: RTL and testbench

Sequencer that writes a parallel word into a chain of one or more i4003 shift registers and reads back the chain's previous contents. It generates cp and serial data with MCS-4-legal pulse widths derived from the system clock period, and it controls the chain's output enable. It sits between a host register interface and the i4003 chain, whose serial_out feeds the next device's serial_in.

---
 rtl/i4003_loader.sv | 146 ++++++++++++++
 tb/tb_i4003_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/i4003_loader.sv
// Serial loader for a chain of i4003 shift registers: shifts a parallel word out on
// cp/sr_data with MCS-4-legal pulse widths and captures the chain's previous contents.
module i4003_loader #(
    parameter int unsigned SYSCLK_TCY         = 20,
    parameter int unsigned CHAIN              = 1,
    parameter int unsigned CP_HIGH_NS         = 500,
    parameter int unsigned CP_LOW_NS          = 500,
    parameter int unsigned BLANK_DURING_SHIFT = 1
) (
    input  logic                  sysclk,
    input  logic                  sysreset_n,
    input  logic [10*CHAIN-1:0]   load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  enable_req,
    output logic [10*CHAIN-1:0]   rd_data,
    output logic                  done,
    output logic                  cp,
    output logic                  sr_data,
    input  logic                  sr_serial_out,
    output logic                  enable
);

    localparam int unsigned W      = 10 * CHAIN;
    localparam int unsigned HI_CY  = (CP_HIGH_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int unsigned LO_CY  = (CP_LOW_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int unsigned MAX_CY = (HI_CY > LO_CY) ? HI_CY : LO_CY;
    localparam int unsigned PH_W   = (MAX_CY > 1) ? $clog2(MAX_CY) : 1;
    localparam int unsigned BC_W   = $clog2(W);
    localparam logic        BLANK  = (BLANK_DURING_SHIFT != 0);

    // cp phases must cover the i4003 latch delay with margin
    generate
        if ((HI_CY * SYSCLK_TCY < 300) || (LO_CY * SYSCLK_TCY < 300)) begin : g_bad_timing
            $error("i4003_loader: cp high/low phase shorter than 300 ns");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [W-1:0]      tx_q, tx_d;
    logic [W-1:0]      rx_q, rx_d;
    logic [W-1:0]      rd_data_q, rd_data_d;
    logic              done_q, done_d;
    logic              cp_q, cp_d;
    logic              sr_data_q, sr_data_d;
    logic              enable_q, enable_d;
    logic              load_ready_q, load_ready_d;

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            bit_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            cp_q         <= 1'b0;
            sr_data_q    <= 1'b0;
            enable_q     <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            cp_q         <= cp_d;
            sr_data_q    <= sr_data_d;
            enable_q     <= enable_d;
            load_ready_q <= load_ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_valid && load_ready_q) begin
                    tx_d    = load_data;
                    bit_d   = '0;
                    phase_d = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_q == PH_W'(LO_CY - 1)) begin
                    // sample the far device's bit 9 before cp rises
                    rx_d    = {rx_q[W-2:0], sr_serial_out};
                    phase_d = '0;
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            HIGH: begin
                if (phase_q == PH_W'(HI_CY - 1)) begin
                    tx_d    = {tx_q[W-2:0], 1'b0};
                    bit_d   = bit_q + BC_W'(1);
                    phase_d = '0;
                    state_d = (bit_q == BC_W'(W - 1)) ? TAIL : LOW;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            TAIL: begin
                if (phase_q == PH_W'(LO_CY - 1)) begin
                    rd_data_d = rx_q;
                    done_d    = 1'b1;
                    phase_d   = '0;
                    state_d   = IDLE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // outputs follow the next state so they line up with the state register
        cp_d         = (state_d == HIGH);
        sr_data_d    = (state_d == LOW) ? tx_d[W-1] : sr_data_q;
        load_ready_d = (state_d == IDLE);
        enable_d     = enable_req & ~(BLANK & ((state_q != IDLE) | (state_d != IDLE)));
    end

    assign load_ready = load_ready_q;
    assign rd_data    = rd_data_q;
    assign done       = done_q;
    assign cp         = cp_q;
    assign sr_data    = sr_data_q;
    assign enable     = enable_q;

endmodule

// File: tb/tb_i4003_loader.sv
// Directed bench for i4003_loader: single-device and three-device chains driven
// against a behavioural shift-register model of the i4003 chain.
module tb_i4003_loader;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n = 1'b0;

    // single device, blanking on
    logic [9:0]  ld1 = '0;
    logic        lv1 = 1'b0;
    logic        er1 = 1'b0;
    logic        lr1, dn1, cp1, sd1, en1;
    logic [9:0]  rd1;
    logic [9:0]  chain1 = '0;

    // three devices, blanking off
    logic [29:0] ld3 = '0;
    logic        lv3 = 1'b0;
    logic        er3 = 1'b0;
    logic        lr3, dn3, cp3, sd3, en3;
    logic [29:0] rd3;
    logic [29:0] chain3 = '0;

    int tests = 0;
    int fails = 0;

    i4003_loader dut1 (
        .sysclk(clk), .sysreset_n(rst_n), .load_data(ld1), .load_valid(lv1),
        .load_ready(lr1), .enable_req(er1), .rd_data(rd1), .done(dn1), .cp(cp1),
        .sr_data(sd1), .sr_serial_out(chain1[9]), .enable(en1)
    );

    i4003_loader #(.CHAIN(3), .BLANK_DURING_SHIFT(0)) dut3 (
        .sysclk(clk), .sysreset_n(rst_n), .load_data(ld3), .load_valid(lv3),
        .load_ready(lr3), .enable_req(er3), .rd_data(rd3), .done(dn3), .cp(cp3),
        .sr_data(sd3), .sr_serial_out(chain3[29]), .enable(en3)
    );

    // chain model: device 0 occupies the low 10 bits, serial_out is the top bit
    always @(posedge cp1) chain1 <= {chain1[8:0], sd1};
    always @(posedge cp3) chain3 <= {chain3[28:0], sd3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one load on the single-device instance, observed cycle by cycle from A+1 to done
    task automatic shift1(input logic [9:0] word, input logic hold, input logic mid,
                          input logic [9:0] exp_rd, input logic [9:0] next_word);
        int rises, hi_bad, lo_bad, sr_bad, en_bad, dn_k, dn_cnt, run;
        logic pcp, psd;
        rises = 0; hi_bad = 0; lo_bad = 0; sr_bad = 0; en_bad = 0;
        dn_k = 0; dn_cnt = 0; run = 0;
        ld1 = word;
        lv1 = 1'b1;
        @(posedge clk); #1;
        if (!hold) lv1 = 1'b0;
        check("ready_low_after_accept", 32'(lr1), 32'(0));
        pcp = 1'b0;
        psd = sd1;
        for (int k = 1; k <= 700 && dn_k == 0; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (mid && k == 100) begin ld1 = ~word; lv1 = 1'b1; end
            if (mid && k == 101) lv1 = 1'b0;
            if (cp1 && !pcp) begin
                rises++;
                if (run != 25) lo_bad++;
                run = 0;
            end else if (!cp1 && pcp) begin
                if (run != 25) hi_bad++;
                run = 0;
            end
            run++;
            if (cp1 && sd1 !== psd) sr_bad++;
            if (en1 !== 1'b0) en_bad++;
            if (dn1) begin dn_k = k; dn_cnt++; end
            pcp = cp1;
            psd = sd1;
        end
        check("cp_pulse_count", 32'(rises), 32'(10));
        check("cp_high_width", 32'(hi_bad), 32'(0));
        check("cp_low_width", 32'(lo_bad), 32'(0));
        check("sr_data_stable", 32'(sr_bad), 32'(0));
        check("enable_blanked", 32'(en_bad), 32'(0));
        check("done_cycle", 32'(dn_k), 32'(526));
        check("ready_in_done_cycle", 32'(lr1), 32'(1));
        check("rd_data", 32'(rd1), 32'(exp_rd));
        check("chain_contents", 32'(chain1), 32'(word));
        if (hold) begin
            ld1 = next_word;
        end else begin
            @(posedge clk); #1;
            check("done_single_pulse", 32'(dn1), 32'(0));
            check("enable_restored", 32'(en1), 32'(1));
        end
    endtask

    task automatic shift3(input logic [29:0] word, input logic [29:0] exp_rd);
        int rises, en_bad, dn_k;
        logic pcp;
        rises = 0; en_bad = 0; dn_k = 0;
        ld3 = word;
        lv3 = 1'b1;
        @(posedge clk); #1;
        lv3 = 1'b0;
        pcp = 1'b0;
        for (int k = 1; k <= 1700 && dn_k == 0; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (cp3 && !pcp) rises++;
            if (en3 !== 1'b1) en_bad++;
            if (dn3) dn_k = k;
            pcp = cp3;
        end
        check("c3_pulse_count", 32'(rises), 32'(30));
        check("c3_enable_unblanked", 32'(en_bad), 32'(0));
        check("c3_done_cycle", 32'(dn_k), 32'(1526));
        check("c3_rd_data", 32'(rd3), 32'(exp_rd));
        check("c3_dev2", 32'(chain3[29:20]), 32'(word[29:20]));
        check("c3_dev1", 32'(chain3[19:10]), 32'(word[19:10]));
        check("c3_dev0", 32'(chain3[9:0]), 32'(word[9:0]));
    endtask

    initial begin
        er1 = 1'b1;
        er3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cp", 32'(cp1), 32'(0));
        check("rst_sr_data", 32'(sd1), 32'(0));
        check("rst_enable", 32'(en1), 32'(0));
        check("rst_done", 32'(dn1), 32'(0));
        check("rst_rd_data", 32'(rd1), 32'(0));
        check("rst_ready", 32'(lr1), 32'(1));
        check("rst_ready_c3", 32'(lr3), 32'(1));
        check("rst_enable_c3", 32'(en3), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_enable", 32'(en1), 32'(1));
        check("idle_enable_c3", 32'(en3), 32'(1));

        shift3(30'h2AAAAAAA, 30'h0);
        check("c3_word_expected", 32'(chain3), 32'h2AAAAAAA);
        shift3(30'h0, 30'h2AAAAAAA);

        shift1(10'h2A5, 1'b0, 1'b0, 10'h000, 10'h000);
        shift1(10'h1C3, 1'b0, 1'b1, 10'h2A5, 10'h000);
        shift1(10'h155, 1'b1, 1'b0, 10'h1C3, 10'h0AA);
        shift1(10'h0AA, 1'b0, 1'b0, 10'h155, 10'h000);
        shift1(10'h000, 1'b0, 1'b0, 10'h0AA, 10'h000);

        // abandon a shift during the high phase of bit 4
        ld1 = 10'h3FF;
        lv1 = 1'b1;
        @(posedge clk); #1;
        lv1 = 1'b0;
        repeat (229) @(posedge clk);
        #1;
        check("mid_cp_high", 32'(cp1), 32'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_cp", 32'(cp1), 32'(0));
        check("mid_rst_enable", 32'(en1), 32'(0));
        check("mid_rst_ready", 32'(lr1), 32'(1));
        check("mid_rst_done", 32'(dn1), 32'(0));
        check("mid_rst_rd_data", 32'(rd1), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        shift1(10'h2A5, 1'b0, 1'b0, 10'h01F, 10'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
